// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a one-word
// registered output slot. It supports two grant modes: fixed select and
// round-robin.
module stream_mux_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N*WIDTH-1:0]          in_data,
    input  logic [N-1:0]                in_valid,
    output logic [N-1:0]                in_ready,
    input  logic                        mode,
    input  logic [((N > 2) ? $clog2(N) : 1)-1:0] sel,
    output logic [WIDTH-1:0]            out_data,
    output logic [((N > 2) ? $clog2(N) : 1)-1:0] out_ch,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int unsigned SW = (N > 2) ? $clog2(N) : 1;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    ptr_q,      ptr_d;

    logic             slot_free;
    logic             gnt;
    logic [SW-1:0]    gidx;
    logic             hi_gnt, lo_gnt;
    logic [SW-1:0]    hi_idx, lo_idx;
    logic             xfer;

    // Grant decision: fixed select, or a round-robin search starting at ptr.
    // The round-robin search finds the lowest valid channel at or above ptr.
    // If there is none, it wraps to the lowest valid channel overall.
    always_comb begin
        gnt    = 1'b0;
        gidx   = '0;
        hi_gnt = 1'b0;
        hi_idx = '0;
        lo_gnt = 1'b0;
        lo_idx = '0;
        if (!mode) begin
            // A sel value that matches no channel index (sel >= N) finds nothing.
            for (int i = 0; i < int'(N); i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    gnt  = 1'b1;
                    gidx = SW'(i);
                end
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    lo_gnt = 1'b1;
                    lo_idx = SW'(i);
                end
                if (in_valid[i] && (SW'(i) >= ptr_q)) begin
                    hi_gnt = 1'b1;
                    hi_idx = SW'(i);
                end
            end
            if (hi_gnt) begin
                gnt  = 1'b1;
                gidx = hi_idx;
            end else if (lo_gnt) begin
                gnt  = 1'b1;
                gidx = lo_idx;
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign xfer      = slot_free && gnt && !rst;

    // Ready is one-hot on the granted channel, and only when the slot can accept.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (xfer && gidx == SW'(i)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Next-state for the output slot and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            for (int i = 0; i < int'(N); i++) begin
                if (gidx == SW'(i)) begin
                    out_data_d = in_data[i*WIDTH +: WIDTH];
                end
            end
            out_ch_d    = gidx;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (gidx == SW'(N - 1)) ? '0 : gidx + SW'(1);
            end
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset wins over any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr. It uses a cycle-by-cycle vector table,
// a round-robin fairness sequence and an N=3 instance for the sel >= N
// boundary.
module tb_stream_mux_rr;

    localparam logic [31:0] D  = 32'h3CA52211;  // ch3=3C ch2=A5 ch1=22 ch0=11
    localparam logic [31:0] D2 = 32'h44337755;  // ch3=44 ch2=33 ch1=77 ch0=55

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  rdy;   // expected in_ready before the edge
        logic        ov;    // expected outputs after the edge
        logic [7:0]  od;
        logic [1:0]  oc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        rst3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                                input logic [3:0] v, input logic [31:0] d,
                                input logic ordy, input logic [3:0] rdy,
                                input logic ov, input logic [7:0] od,
                                input logic [1:0] oc);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = s; t.iv = v; t.data = d; t.ordy = ordy;
        t.rdy = rdy; t.ov = ov; t.od = od; t.oc = oc;
        return t;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    vec_t tbl[20];

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; in_valid3 = '0; in_data3 = 24'h332211;
        out_ready3 = 1'b1;

        //             rst mode sel iv       data ordy rdy      ov od     oc
        tbl[0]  = mk(1, 1, 0, 4'hF,    D,  1, 4'b0000, 0, 8'h00, 0); // reset beats transfer
        tbl[1]  = mk(0, 0, 2, 4'hF,    D,  1, 4'b0100, 1, 8'hA5, 2); // fixed select ch2
        tbl[2]  = mk(0, 0, 3, 4'b0111, D,  1, 4'b0000, 0, 8'hA5, 2); // sel invalid: drain, hold
        tbl[3]  = mk(0, 1, 0, 4'hF,    D,  1, 4'b0001, 1, 8'h11, 0); // ptr untouched by mode 0
        tbl[4]  = mk(0, 1, 0, 4'hF,    D,  1, 4'b0010, 1, 8'h22, 1);
        tbl[5]  = mk(0, 1, 0, 4'hF,    D,  1, 4'b0100, 1, 8'hA5, 2); // ptr -> 3
        tbl[6]  = mk(0, 1, 0, 4'b0011, D,  1, 4'b0001, 1, 8'h11, 0); // skip + wrap to 0
        tbl[7]  = mk(0, 1, 0, 4'b0011, D,  1, 4'b0010, 1, 8'h22, 1); // ptr=1 -> ch1
        tbl[8]  = mk(0, 1, 0, 4'b1000, D,  1, 4'b1000, 1, 8'h3C, 3); // load 3C, ptr -> 0
        tbl[9]  = mk(0, 1, 0, 4'hF,    D2, 0, 4'b0000, 1, 8'h3C, 3); // backpressure
        tbl[10] = mk(0, 0, 1, 4'b0101, D2, 0, 4'b0000, 1, 8'h3C, 3);
        tbl[11] = mk(0, 1, 0, 4'b1010, D,  0, 4'b0000, 1, 8'h3C, 3);
        tbl[12] = mk(0, 0, 1, 4'b0010, D2, 1, 4'b0010, 1, 8'h77, 1); // consume + replace
        tbl[13] = mk(0, 1, 0, 4'hF,    D2, 1, 4'b0001, 1, 8'h55, 0); // ptr -> 1
        tbl[14] = mk(0, 1, 0, 4'h0,    D2, 1, 4'b0000, 0, 8'h55, 0); // idle drains
        tbl[15] = mk(0, 1, 0, 4'hF,    D2, 1, 4'b0010, 1, 8'h77, 1); // ptr held at 1 -> 2
        tbl[16] = mk(0, 1, 0, 4'hF,    D2, 0, 4'b0000, 1, 8'h77, 1); // held word
        tbl[17] = mk(1, 1, 0, 4'hF,    D2, 0, 4'b0000, 0, 8'h00, 0); // reset discards it
        tbl[18] = mk(0, 1, 0, 4'hF,    D2, 0, 4'b0001, 1, 8'h55, 0); // first RR grant is ch0
        tbl[19] = mk(0, 1, 0, 4'hF,    D2, 1, 4'b0010, 1, 8'h77, 1);

        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; mode = tbl[i].mode; sel = tbl[i].sel;
            in_valid = tbl[i].iv; in_data = tbl[i].data; out_ready = tbl[i].ordy;
            #1;
            n_vec++;
            chk("in_ready", i, 32'(in_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk("out_valid", i, 32'(out_valid), 32'(tbl[i].ov));
            chk("out_data", i, 32'(out_data), 32'(tbl[i].od));
            chk("out_ch", i, 32'(out_ch), 32'(tbl[i].oc));
        end

        // Round-robin fairness: all channels valid after reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = D;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] ech;
            logic [3:0] erdy;
            ech  = 2'(k % 4);
            erdy = 4'b0001 << ech;
            #1;
            n_vec++;
            chk("rr_ready", 100 + k, 32'(in_ready), 32'(erdy));
            @(posedge clk);
            #1;
            chk("rr_valid", 100 + k, 32'(out_valid), 32'd1);
            chk("rr_ch", 100 + k, 32'(out_ch), 32'(ech));
            @(negedge clk);
        end

        // N=3: sel = 3 has no channel, and the round-robin wraps at 2.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        n_vec++;
        chk("n3_sel_oob_ready", 200, 32'(in_ready3), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_sel_oob_valid", 200, 32'(out_valid3), 32'd0);
        @(negedge clk);
        mode3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ech;
            logic [7:0] ed;
            ech = 2'(k % 3);
            ed  = 8'(in_data3 >> (8 * (k % 3)));
            @(posedge clk);
            #1;
            n_vec++;
            chk("n3_rr_ch", 210 + k, 32'(out_ch3), 32'(ech));
            chk("n3_rr_data", 210 + k, 32'(out_data3), 32'(ed));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
